mem_port_arbiter: RTL and testbench

Arbitrates the single unified memory port between the instruction-fetch (IF) stage and the data-access (MEM) stage of the 5-stage MIPS pipeline. It runs a multi-cycle access FSM and generates pipeline freeze signals in the same style as the load-use hazard unit: PCWrite and IFIDWrite low while fetch waits, and PipeStall high while a data access waits. Sits between the IF/MEM stages and the memory model, alongside the hazard unit.

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: serialises IF fetches and MEM data accesses over one port.
// Define ARB_PERF_CNT_EN to build the fetch/data stall-cycle counters.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IFReq,
    input  logic [ADDR_W-1:0] IFAddr,
    output logic [DATA_W-1:0] IFRdata,
    output logic              IFReady,
    input  logic              MEMRead,
    input  logic              MEMWrite,
    input  logic [ADDR_W-1:0] MEMAddr,
    input  logic [DATA_W-1:0] MEMWdata,
    output logic [DATA_W-1:0] MEMRdata,
    output logic              MEMReady,
    output logic              MemEn,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic [DATA_W-1:0] MemRdata,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              PipeStall,
    output logic [31:0]       IFStallCnt,
    output logic [31:0]       MEMStallCnt
);

    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_check
        $error("mem_port_arbiter: MEM_LAT=%0d must be in 1..4", MEM_LAT);
    end

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACC_I,
        ACC_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_d_q, last_d_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              if_ready_q, if_ready_d;
    logic              mem_ready_q, mem_ready_d;

    logic dreq;
    logic grant_d;
    logic grant_i;

    assign dreq    = MEMRead | MEMWrite;
    // On contention the side that did not win last time goes first.
    assign grant_d = dreq & (~IFReq | ~last_d_q);
    assign grant_i = IFReq & (~dreq | last_d_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d  = ACC_D;
                    addr_d   = MEMAddr;
                    wdata_d  = MEMWdata;
                    we_d     = MEMWrite;
                    cnt_d    = CNT_INIT;
                    last_d_d = 1'b1;
                end else if (grant_i) begin
                    state_d  = ACC_I;
                    addr_d   = IFAddr;
                    cnt_d    = CNT_INIT;
                    last_d_d = 1'b0;
                end
            end
            ACC_I: begin
                if (cnt_q == 2'd0) begin
                    if_rdata_d = MemRdata;
                    state_d    = RESP_I;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ACC_D: begin
                if (cnt_q == 2'd0) begin
                    if (!we_q) begin
                        mem_rdata_d = MemRdata;
                    end
                    state_d = RESP_D;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Port controls and ready pulses are decoded from the next state so they leave a flop.
        mem_en_d    = (state_d == ACC_I) || (state_d == ACC_D);
        mem_we_d    = (state_d == ACC_D) && we_d;
        if_ready_d  = (state_d == RESP_I);
        mem_ready_d = (state_d == RESP_D);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_d_q    <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_d_q    <= last_d_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign MemEn    = mem_en_q;
    assign MemWE    = mem_we_q;
    assign MemAddr  = addr_q;
    assign MemWdata = wdata_q;
    assign IFRdata  = if_rdata_q;
    assign MEMRdata = mem_rdata_q;
    assign IFReady  = if_ready_q;
    assign MEMReady = mem_ready_q;

    assign PipeStall = dreq & ~mem_ready_q;
    assign PCWrite   = ~PipeStall & ~(IFReq & ~if_ready_q);
    assign IFIDWrite = PCWrite;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt_q, if_stall_cnt_d;
    logic [31:0] mem_stall_cnt_q, mem_stall_cnt_d;

    always_comb begin
        if_stall_cnt_d  = if_stall_cnt_q;
        mem_stall_cnt_d = mem_stall_cnt_q;
        if ((IFReq & ~if_ready_q) && (if_stall_cnt_q != '1)) begin
            if_stall_cnt_d = if_stall_cnt_q + 32'd1;
        end
        if (PipeStall && (mem_stall_cnt_q != '1)) begin
            mem_stall_cnt_d = mem_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_stall_cnt_q  <= '0;
            mem_stall_cnt_q <= '0;
        end else begin
            if_stall_cnt_q  <= if_stall_cnt_d;
            mem_stall_cnt_q <= mem_stall_cnt_d;
        end
    end

    assign IFStallCnt  = if_stall_cnt_q;
    assign MEMStallCnt = mem_stall_cnt_q;
`else
    assign IFStallCnt  = '0;
    assign MEMStallCnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random two-agent traffic
// checked against a cycle-arithmetic model of grant/latency rules.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IFReq = 1'b0;
    logic [31:0] IFAddr = '0;
    logic [31:0] IFRdata;
    logic        IFReady;
    logic        MEMRead = 1'b0;
    logic        MEMWrite = 1'b0;
    logic [31:0] MEMAddr = '0;
    logic [31:0] MEMWdata = '0;
    logic [31:0] MEMRdata;
    logic        MEMReady;
    logic        MemEn;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata = '0;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        PipeStall;
    logic [31:0] IFStallCnt;
    logic [31:0] MEMStallCnt;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .IFReq(IFReq), .IFAddr(IFAddr), .IFRdata(IFRdata), .IFReady(IFReady),
        .MEMRead(MEMRead), .MEMWrite(MEMWrite), .MEMAddr(MEMAddr), .MEMWdata(MEMWdata),
        .MEMRdata(MEMRdata), .MEMReady(MEMReady),
        .MemEn(MemEn), .MemWE(MemWE), .MemAddr(MemAddr), .MemWdata(MemWdata), .MemRdata(MemRdata),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .PipeStall(PipeStall),
        .IFStallCnt(IFStallCnt), .MEMStallCnt(MEMStallCnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: one transaction owns the port from grant cycle m_start
    // until its ready cycle m_start+LAT+1.
    int          cyc = 0;
    bit          m_busy = 1'b0, m_own_d = 1'b0, m_wr = 1'b0, m_lastd = 1'b0;
    int          m_start = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ifr = '0, m_memr = '0;
    logic [31:0] m_ifcnt = '0, m_memcnt = '0;
    bit          e_ifr_prev = 1'b0, e_memr_prev = 1'b0;

    logic        o_en, o_we, o_ifrdy, o_memrdy, o_ps, o_pcw, o_ifid;
    logic [31:0] o_addr, o_wdata, o_ifrdata, o_memrdata, o_ifcnt, o_memcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ifq, input logic [31:0] ifa,
                        input bit rd, input bit wr, input logic [31:0] ma,
                        input logic [31:0] wd, input logic [31:0] mrd);
        bit acc, rdy, dreq, e_ifrdy, e_memrdy, e_ps, e_pcw;
        reset = rst; IFReq = ifq; IFAddr = ifa; MEMRead = rd; MEMWrite = wr;
        MEMAddr = ma; MEMWdata = wd; MemRdata = mrd;
        @(negedge clk);
        acc      = m_busy && (cyc >= m_start + 1) && (cyc <= m_start + LAT);
        rdy      = m_busy && (cyc == m_start + LAT + 1);
        e_ifrdy  = rdy && !m_own_d;
        e_memrdy = rdy && m_own_d;
        dreq     = rd || wr;
        e_ps     = dreq && !e_memrdy;
        e_pcw    = !e_ps && !(ifq && !e_ifrdy);
        o_en = MemEn; o_we = MemWE; o_addr = MemAddr; o_wdata = MemWdata;
        o_ifrdy = IFReady; o_memrdy = MEMReady; o_ifrdata = IFRdata; o_memrdata = MEMRdata;
        o_ps = PipeStall; o_pcw = PCWrite; o_ifid = IFIDWrite;
        o_ifcnt = IFStallCnt; o_memcnt = MEMStallCnt;
        if (chk_en) begin
            chk("MemEn", o_en, acc);
            chk("MemWE", o_we, acc && m_own_d && m_wr);
            chk("MemAddr", o_addr, m_addr);
            chk("MemWdata", o_wdata, m_wdata);
            chk("IFReady", o_ifrdy, e_ifrdy);
            chk("MEMReady", o_memrdy, e_memrdy);
            chk("IFRdata", o_ifrdata, m_ifr);
            chk("MEMRdata", o_memrdata, m_memr);
            chk("PipeStall", o_ps, e_ps);
            chk("PCWrite", o_pcw, e_pcw);
            chk("IFIDWrite", o_ifid, e_pcw);
`ifdef ARB_PERF_CNT_EN
            chk("IFStallCnt", o_ifcnt, m_ifcnt);
            chk("MEMStallCnt", o_memcnt, m_memcnt);
`else
            chk("IFStallCnt", o_ifcnt, 32'h0);
            chk("MEMStallCnt", o_memcnt, 32'h0);
`endif
        end
        if (rst) begin
            m_busy = 0; m_lastd = 0; m_wr = 0; m_own_d = 0;
            m_addr = '0; m_wdata = '0; m_ifr = '0; m_memr = '0;
            m_ifcnt = '0; m_memcnt = '0;
        end else begin
            if (acc && cyc == m_start + LAT) begin
                if (!m_own_d) m_ifr = mrd;
                else if (!m_wr) m_memr = mrd;
            end
            if (ifq && !e_ifrdy && m_ifcnt != 32'hFFFF_FFFF) m_ifcnt++;
            if (e_ps && m_memcnt != 32'hFFFF_FFFF) m_memcnt++;
            if (m_busy) begin
                if (rdy) m_busy = 0;
            end else if (dreq && (!ifq || !m_lastd)) begin
                m_busy = 1; m_own_d = 1; m_start = cyc; m_lastd = 1;
                m_addr = ma; m_wdata = wd; m_wr = wr;
            end else if (ifq) begin
                m_busy = 1; m_own_d = 0; m_start = cyc; m_lastd = 0;
                m_addr = ifa;
            end
        end
        e_ifr_prev  = e_ifrdy;
        e_memr_prev = e_memrdy;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          if_p, d_p, d_rd, d_wr, rst;
        logic [31:0] ia, da, dw;
        int unsigned sel;
        if_p = 0; d_p = 0; d_rd = 0; d_wr = 0; ia = '0; da = '0; dw = '0;

        @(posedge clk);
        #1;
        step(1, 0, '0, 0, 0, '0, '0, '0);
        chk_en = 1'b1;
        step(1, 0, '0, 0, 0, '0, '0, '0);

        // Idle after reset
        for (int k = 0; k < 5; k++) begin
            step(0, 0, '0, 0, 0, '0, '0, '0);
            chk("t1_pcw", o_pcw, 1'b1);
            chk("t1_ifid", o_ifid, 1'b1);
            chk("t1_ps", o_ps, 1'b0);
            chk("t1_en", o_en, 1'b0);
            chk("t1_rdy", {o_ifrdy, o_memrdy}, 2'b00);
        end

        // Single fetch
        for (int k = 0; k < 5; k++) begin
            step(0, k <= 3, 32'h40, 0, 0, '0, '0, 32'h8C22_0004);
            if (k == 0) chk("t2_pcw0", o_pcw, 1'b0);
            if (k == 1 || k == 2) begin
                chk("t2_en", o_en, 1'b1);
                chk("t2_addr", o_addr, 32'h40);
                chk("t2_pcw", o_pcw, 1'b0);
            end
            if (k == 3) begin
                chk("t2_ifrdy", o_ifrdy, 1'b1);
                chk("t2_ifrdata", o_ifrdata, 32'h8C22_0004);
                chk("t2_pcw3", o_pcw, 1'b1);
            end
        end

        // Simultaneous fetch and read after reset: data wins first
        step(1, 0, '0, 0, 0, '0, '0, '0);
        for (int k = 0; k < 9; k++) begin
            step(0, k <= 7, 32'h44, k <= 3, 0, 32'h200, '0, 32'hA000_0000 | k);
            if (k == 1) chk("t3_daddr", o_addr, 32'h200);
            if (k == 3) begin
                chk("t3_memrdy", o_memrdy, 1'b1);
                chk("t3_memrdata", o_memrdata, 32'hA000_0002);
            end
            if (k >= 3) chk("t3_ps", o_ps, 1'b0);
            if (k == 4) chk("t3_en4", o_en, 1'b0);
            if (k == 5) chk("t3_iaddr", o_addr, 32'h44);
            if (k == 7) begin
                chk("t3_ifrdy", o_ifrdy, 1'b1);
                chk("t3_ifrdata", o_ifrdata, 32'hA000_0006);
            end
`ifdef ARB_PERF_CNT_EN
            if (k == 8) begin
                chk("t3_ifcnt", o_ifcnt, 32'd7);
                chk("t3_memcnt", o_memcnt, 32'd3);
            end
`endif
        end

        // Write: MEMRdata keeps the earlier read value
        for (int k = 0; k < 5; k++) begin
            step(0, 0, '0, 0, k <= 3, 32'h100, 32'hDEAD_BEEF, 32'h5555_5555);
            if (k == 1 || k == 2) begin
                chk("t4_we", o_we, 1'b1);
                chk("t4_addr", o_addr, 32'h100);
                chk("t4_wdata", o_wdata, 32'hDEAD_BEEF);
            end
            if (k == 3) begin
                chk("t4_memrdy", o_memrdy, 1'b1);
                chk("t4_memrdata", o_memrdata, 32'hA000_0002);
            end
            if (k == 4) chk("t4_we4", o_we, 1'b0);
        end

        // Reset during the first write access cycle
        for (int k = 0; k < 5; k++) begin
            step(k == 1, 0, '0, 0, k <= 1, 32'h300, 32'h1234_5678, '0);
            if (k == 1) chk("t5_we1", o_we, 1'b1);
            if (k >= 2) begin
                chk("t5_we", o_we, 1'b0);
                chk("t5_en", o_en, 1'b0);
                chk("t5_memrdy", o_memrdy, 1'b0);
            end
        end

        // Random traffic from a fetch agent and a data agent
        for (int n = 0; n < 3000; n++) begin
            if (e_ifr_prev) if_p = 0;
            if (e_memr_prev) d_p = 0;
            if (!if_p && $urandom_range(0, 2) == 0) begin
                if_p = 1; ia = $urandom;
            end
            if (!d_p && $urandom_range(0, 2) == 0) begin
                d_p = 1; sel = $urandom_range(0, 7);
                d_rd = (sel < 4) || (sel == 7);
                d_wr = (sel >= 4);
                da = $urandom; dw = $urandom;
            end
            if ($urandom_range(0, 63) == 0) if_p = 0;
            if ($urandom_range(0, 63) == 0) d_p = 0;
            rst = ($urandom_range(0, 199) == 0);
            step(rst, if_p, ia, d_p && d_rd, d_p && d_wr, da, dw, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
